// File: rtl/coeff_unpack.sv
// coeff_unpack: turns (size, run) codes from the table-2 lookup into a
// stream of zig-zag indexed coefficients. Each code emits run_length zeros,
// then pulls coeff_size raw bits (MSB first) and emits one sign-decoded
// coefficient. The index wraps every 16 coefficients (one 4x4 block).
//
// Handshakes: code_valid/code_ready and bit_valid/bit_ready transfer on a
// rising phi1 edge where both are high. The ready outputs depend only on
// state, never on the matching valid. Outputs have no backpressure: the
// consumer must take every coeff_valid pulse.
module coeff_unpack #(
    parameter int COEFF_W  = 12,
    parameter int MAX_SIZE = 11
) (
    input  logic               phi1,
    input  logic               reset,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic [3:0]         coeff_size,
    input  logic [1:0]         run_length,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [COEFF_W-1:0] coeff_out,
    output logic               coeff_valid,
    output logic [3:0]         coeff_idx,
    output logic               block_done,
    output logic               size_err,
    output logic [1:0]         state_dbg
);

    localparam logic [3:0] MAX_SIZE_4 = 4'(MAX_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ZERO  = 2'd1,
        S_SHIFT = 2'd2,
        S_EMIT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           size_q, size_d;
    logic [1:0]           run_q, run_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [MAX_SIZE-1:0]  acc_q, acc_d;
    logic [3:0]           idx_q, idx_d;
    logic [COEFF_W-1:0]   coeff_out_q, coeff_out_d;
    logic                 coeff_valid_q, coeff_valid_d;
    logic [3:0]           coeff_idx_q, coeff_idx_d;
    logic                 block_done_q, block_done_d;
    logic                 size_err_q, size_err_d;

    logic                 emit_en;
    logic [COEFF_W-1:0]   emit_val;

    logic [MAX_SIZE-1:0]  acc_shifted;
    logic                 raw_msb;
    logic [COEFF_W-1:0]   raw_ext;
    logic [COEFF_W-1:0]   size_mask;
    logic [COEFF_W-1:0]   decoded;

    // A size needs bits pulled only when it is non-zero and within range.
    function automatic logic size_legal(input logic [3:0] s);
        return (s != 4'd0) && (s <= MAX_SIZE_4);
    endfunction

    // JPEG-style sign decode of the accumulated raw bits. The accumulator is
    // cleared on accept, so its low size_q bits are exactly the raw value.
    always_comb begin
        acc_shifted = acc_q >> (size_q - 4'd1);
        raw_msb     = acc_shifted[0];
        raw_ext     = {{(COEFF_W-MAX_SIZE){1'b0}}, acc_q};
        size_mask   = (COEFF_W'(1) << size_q) - COEFF_W'(1);
        if (!size_legal(size_q)) begin
            decoded = '0;
        end else if (raw_msb) begin
            decoded = raw_ext;
        end else begin
            decoded = raw_ext - size_mask;
        end
    end

    // Next-state and output logic; emissions from ZERO and EMIT share one path.
    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        run_d         = run_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        coeff_out_d   = coeff_out_q;
        coeff_valid_d = 1'b0;
        coeff_idx_d   = coeff_idx_q;
        block_done_d  = 1'b0;
        size_err_d    = size_err_q;
        emit_en       = 1'b0;
        emit_val      = '0;

        case (state_q)
            S_IDLE: begin
                if (code_valid) begin
                    size_d = coeff_size;
                    run_d  = run_length;
                    cnt_d  = coeff_size;
                    acc_d  = '0;
                    if (coeff_size > MAX_SIZE_4) begin
                        size_err_d = 1'b1;
                    end
                    if (run_length != 2'd0) begin
                        state_d = S_ZERO;
                    end else if (size_legal(coeff_size)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_ZERO: begin
                emit_en  = 1'b1;
                emit_val = '0;
                run_d    = run_q - 2'd1;
                if (run_q == 2'd1) begin
                    state_d = size_legal(size_q) ? S_SHIFT : S_EMIT;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    acc_d = {acc_q[MAX_SIZE-2:0], bit_in};
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                emit_en  = 1'b1;
                emit_val = decoded;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (emit_en) begin
            coeff_valid_d = 1'b1;
            coeff_out_d   = emit_val;
            coeff_idx_d   = idx_q;
            block_done_d  = (idx_q == 4'd15);
            idx_d         = idx_q + 4'd1;
        end
    end

    // State and output registers; reset discards any partial code.
    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q       <= S_IDLE;
            size_q        <= '0;
            run_q         <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            coeff_out_q   <= '0;
            coeff_valid_q <= 1'b0;
            coeff_idx_q   <= '0;
            block_done_q  <= 1'b0;
            size_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            coeff_out_q   <= coeff_out_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_idx_q   <= coeff_idx_d;
            block_done_q  <= block_done_d;
            size_err_q    <= size_err_d;
        end
    end

    assign code_ready  = (state_q == S_IDLE);
    assign bit_ready   = (state_q == S_SHIFT);
    assign coeff_out   = coeff_out_q;
    assign coeff_valid = coeff_valid_q;
    assign coeff_idx   = coeff_idx_q;
    assign block_done  = block_done_q;
    assign size_err    = size_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_coeff_unpack.sv
// Bench for coeff_unpack: directed scenarios plus randomized codes, checked
// against a queue-based model computed from the decode rules.
module tb_coeff_unpack;

    localparam int COEFF_W = 12;
    localparam int EW      = 17; // {block_done, idx[3:0], coeff[11:0]}

    logic               phi1 = 1'b0;
    logic               reset;
    logic               code_valid;
    logic               code_ready;
    logic [3:0]         coeff_size;
    logic [1:0]         run_length;
    logic               bit_in;
    logic               bit_valid;
    logic               bit_ready;
    logic [COEFF_W-1:0] coeff_out;
    logic               coeff_valid;
    logic [3:0]         coeff_idx;
    logic               block_done;
    logic               size_err;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mp       = 0;
    int n_consumed = 0;
    int m_idx    = 0;

    logic [EW-1:0] exp_q[$];

    coeff_unpack #(.COEFF_W(12), .MAX_SIZE(11)) dut (
        .phi1        (phi1),
        .reset       (reset),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .coeff_size  (coeff_size),
        .run_length  (run_length),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .coeff_out   (coeff_out),
        .coeff_valid (coeff_valid),
        .coeff_idx   (coeff_idx),
        .block_done  (block_done),
        .size_err    (size_err),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter.
    always #5 phi1 = ~phi1;

    always @(posedge phi1) begin
        cyc <= cyc + 1;
        if (!reset && bit_ready && bit_valid) begin
            n_consumed <= n_consumed + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode straight from the size/raw rules.
    function automatic logic [11:0] ref_decode(input int size, input int raw);
        int v;
        if (size == 0 || size > 11) return 12'd0;
        if (raw >= (1 << (size - 1))) v = raw;
        else v = raw - ((1 << size) - 1);
        return 12'(v);
    endfunction

    function automatic void model_push(input logic [11:0] val);
        logic [3:0] ix;
        ix = 4'(m_idx);
        exp_q.push_back({(m_idx == 15), ix, val});
        m_idx = (m_idx + 1) % 16;
    endfunction

    // Scoreboard: every pulse must match the head of the expected queue.
    always @(negedge phi1) begin
        logic [EW-1:0] e;
        if (coeff_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(coeff_idx), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("coeff", 32'(coeff_out), 32'(e[11:0]));
                check("idx", 32'(coeff_idx), 32'(e[15:12]));
                check("block_done", 32'(block_done), 32'(e[16]));
            end
        end else begin
            check("done_idle", 32'(block_done), 32'd0);
        end
    end

    task automatic tick();
        @(negedge phi1);
        if (coeff_valid) mp++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        code_valid = 1'b0;
        bit_valid = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        m_idx = 0;
    endtask

    // Drive one code and its bits; checks pulse count and latency.
    task automatic send_code(input int size, input int run, input logic [15:0] bits,
                             input int stall_at, input int stall_len, input bit rand_stall);
        int eff, consumed, stalls, stall_left, g, acc_cyc, lat;
        logic rdy, v;
        eff = (size > 0 && size <= 11) ? size : 0;
        g = 0;
        while (!code_ready && g < 100) begin
            tick();
            g++;
        end
        check("code_ready_wait", 32'(code_ready), 32'd1);
        for (int k = 0; k < run; k++) model_push(12'd0);
        model_push(ref_decode(size, int'(bits) & ((1 << eff) - 1)));
        code_valid = 1'b1;
        coeff_size = 4'(size);
        run_length = 2'(run);
        tick();
        mp = 0;
        acc_cyc = cyc;
        code_valid = 1'b0;
        coeff_size = 4'($urandom);
        run_length = 2'($urandom);
        check("busy_after_accept", 32'(code_ready), 32'd0);
        consumed = 0;
        stalls = 0;
        stall_left = stall_len;
        g = 0;
        while (consumed < eff && g < 300) begin
            rdy = bit_ready;
            v = 1'b1;
            if (rdy && consumed == stall_at && stall_left > 0) begin
                v = 1'b0;
                stall_left--;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                v = 1'b0;
            end
            bit_valid = v;
            bit_in = rdy ? bits[eff - 1 - consumed] : 1'($urandom);
            tick();
            if (rdy && v) consumed++;
            else if (rdy) stalls++;
            g++;
        end
        check("bits_taken", 32'(consumed), 32'(eff));
        bit_valid = 1'b1;
        bit_in = 1'($urandom);
        g = 0;
        while (mp < run + 1 && g < 60) begin
            tick();
            g++;
        end
        check("pulse_count", 32'(mp), 32'(run + 1));
        // The consumer captures the pulse on the edge after it appears.
        lat = cyc + 1 - acc_cyc;
        check("latency", 32'(lat), 32'(run + eff + 2 + stalls));
        bit_valid = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int c0, sz, rn;
        logic [15:0] b;
        reset = 1'b1;
        code_valid = 1'b0;
        coeff_size = '0;
        run_length = '0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_coeff_out", 32'(coeff_out), 32'd0);
        check("rst_coeff_valid", 32'(coeff_valid), 32'd0);
        check("rst_coeff_idx", 32'(coeff_idx), 32'd0);
        check("rst_block_done", 32'(block_done), 32'd0);
        check("rst_size_err", 32'(size_err), 32'd0);
        check("rst_code_ready", 32'(code_ready), 32'd1);
        check("rst_bit_ready", 32'(bit_ready), 32'd0);

        // size 3 run 0, bits 101 -> +5 at idx 0
        send_code(3, 0, 16'b101, -1, 0, 1'b0);
        // size 3 run 2, bits 011 -> 0, 0, -4
        send_code(3, 2, 16'b011, -1, 0, 1'b0);

        // Eight size-1 run-1 codes fill one block exactly, then wrap to idx 0.
        do_reset();
        for (int i = 0; i < 8; i++) send_code(1, 1, 16'b1, -1, 0, 1'b0);
        send_code(2, 0, 16'b11, -1, 0, 1'b0);

        // size 4 with three stall cycles after the second bit -> -9
        send_code(4, 0, 16'b0110, 2, 3, 1'b0);

        // Illegal size: sticky error, no bits taken, zero emitted.
        c0 = n_consumed;
        send_code(13, 0, 16'h0, -1, 0, 1'b0);
        check("illegal_no_bits", 32'(n_consumed - c0), 32'd0);
        check("size_err_set", 32'(size_err), 32'd1);
        send_code(2, 1, 16'b01, -1, 0, 1'b0);
        check("size_err_sticky", 32'(size_err), 32'd1);

        // Reset in SHIFT after 2 of 5 bits.
        code_valid = 1'b1;
        coeff_size = 4'd5;
        run_length = 2'd0;
        tick();
        code_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'b1;
            tick();
        end
        reset = 1'b1;
        bit_valid = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        m_idx = 0;
        check("rst6_valid0", 32'(coeff_valid), 32'd0);
        check("rst6_idx", 32'(coeff_idx), 32'd0);
        check("rst6_ready", 32'(code_ready), 32'd1);
        check("rst6_size_err", 32'(size_err), 32'd0);
        tick();
        check("rst6_valid1", 32'(coeff_valid), 32'd0);
        send_code(5, 0, 16'b10010, -1, 0, 1'b0);

        // Randomized codes with random bit stalls.
        for (int i = 0; i < 40; i++) begin
            sz = $urandom_range(0, 13);
            rn = $urandom_range(0, 3);
            b = (sz > 0 && sz <= 11) ? 16'($urandom_range(0, (1 << sz) - 1)) : 16'h0;
            send_code(sz, rn, b, -1, 0, 1'b1);
        end

        repeat (4) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
